// File: rtl/door_access_sequencer.sv
// -----------------------------------------------------------------------------
// door_access_sequencer
//   Door latch controller. Arbitrates access requests from three sources
//   (admin/HPS, card reader, keypad), releases the latch for a bounded unlock
//   window, watches the door contact for an ajar condition, and locks out the
//   card and keypad after repeated denied attempts.
//
// Ports
//   FPGA_CLK1_50   in   system clock (50 MHz)
//   reset_n        in   asynchronous active-low reset
//   req[2:0]       in   one-cycle request pulses: [0] admin, [1] card, [2] keypad
//   cred_ok[2:0]   in   credential valid, qualified by the matching req bit
//   avail_set      in   pulse: room becomes available
//   avail_clr      in   pulse: room becomes unavailable (wins over avail_set)
//   door_closed    in   synchronised door contact, 1 = closed
//   lock_output    out  1 = latch released
//   grant[2:0]     out  one-hot pulse naming the accepted source
//   denied         out  pulse on a rejected request
//   alarm          out  door held open too long
//   room_available out  current availability flag
//   locked_out     out  1 while in lockout
// -----------------------------------------------------------------------------
module door_access_sequencer #(
  parameter int unsigned UNLOCK_CYCLES  = 150000000,
  parameter int unsigned AJAR_CYCLES    = 1500000000,
  parameter int unsigned LOCKOUT_CYCLES = 500000000,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic       FPGA_CLK1_50,
  input  logic       reset_n,
  input  logic [2:0] req,
  input  logic [2:0] cred_ok,
  input  logic       avail_set,
  input  logic       avail_clr,
  input  logic       door_closed,
  output logic       lock_output,
  output logic [2:0] grant,
  output logic       denied,
  output logic       alarm,
  output logic       room_available,
  output logic       locked_out
);

  localparam int FW = $clog2(MAX_FAILS + 1);

  localparam logic [30:0] LOAD_UNLOCK  = 31'(UNLOCK_CYCLES - 1);
  localparam logic [30:0] LOAD_AJAR    = 31'(AJAR_CYCLES - 1);
  localparam logic [30:0] LOAD_LOCKOUT = 31'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UNLOCK  = 3'd1,
    S_OPEN    = 3'd2,
    S_AJAR    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t        state;
  logic [30:0]   cnt;
  logic [FW-1:0] fail_cnt;

  logic [2:0] win;
  logic       win_ok;
  logic       fails_at_limit;

  // Fixed-priority pick of a single request; losers are simply dropped.
  always_comb begin
    win = 3'b000;
    if (req[0])      win = 3'b001;
    else if (req[1]) win = 3'b010;
    else if (req[2]) win = 3'b100;
  end

  assign win_ok         = |(win & cred_ok);
  assign fails_at_limit = (32'(fail_cnt) + 32'd1) >= MAX_FAILS;

  // Outputs are registered alongside the state, so each branch sets the
  // output levels that belong to the state being entered.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      fail_cnt       <= '0;
      room_available <= 1'b0;
      lock_output    <= 1'b0;
      grant          <= 3'b000;
      denied         <= 1'b0;
      alarm          <= 1'b0;
      locked_out     <= 1'b0;
    end else begin
      grant  <= 3'b000;
      denied <= 1'b0;

      if (avail_clr)      room_available <= 1'b0;
      else if (avail_set) room_available <= 1'b1;

      case (state)
        S_IDLE: begin
          if (win != 3'b000) begin
            // Admin bypasses the availability flag; card/keypad need it.
            if (win_ok && (win[0] || room_available)) begin
              grant       <= win;
              state       <= S_UNLOCK;
              cnt         <= LOAD_UNLOCK;
              fail_cnt    <= '0;
              lock_output <= 1'b1;
            end else begin
              denied <= 1'b1;
              if (fails_at_limit) begin
                state      <= S_LOCKOUT;
                cnt        <= LOAD_LOCKOUT;
                fail_cnt   <= '0;
                locked_out <= 1'b1;
              end else begin
                fail_cnt <= fail_cnt + FW'(1);
              end
            end
          end
        end

        S_UNLOCK: begin
          // Door opening takes precedence over the window expiring.
          if (!door_closed) begin
            state       <= S_OPEN;
            cnt         <= LOAD_AJAR;
            lock_output <= 1'b0;
          end else if (cnt == 31'd0) begin
            state       <= S_IDLE;
            lock_output <= 1'b0;
          end else begin
            cnt <= cnt - 31'd1;
          end
        end

        S_OPEN: begin
          if (door_closed) begin
            state <= S_IDLE;
          end else if (cnt == 31'd0) begin
            state <= S_AJAR;
            alarm <= 1'b1;
          end else begin
            cnt <= cnt - 31'd1;
          end
        end

        S_AJAR: begin
          if (door_closed) begin
            state <= S_IDLE;
            alarm <= 1'b0;
          end
        end

        S_LOCKOUT: begin
          // Only a valid admin credential escapes lockout early; everything
          // else is denied without touching the failure count.
          if (win[0] && cred_ok[0]) begin
            grant       <= 3'b001;
            state       <= S_UNLOCK;
            cnt         <= LOAD_UNLOCK;
            fail_cnt    <= '0;
            locked_out  <= 1'b0;
            lock_output <= 1'b1;
          end else begin
            if (win != 3'b000) denied <= 1'b1;
            if (cnt == 31'd0) begin
              state      <= S_IDLE;
              locked_out <= 1'b0;
            end else begin
              cnt <= cnt - 31'd1;
            end
          end
        end

        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          fail_cnt    <= '0;
          lock_output <= 1'b0;
          alarm       <= 1'b0;
          locked_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule
